// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for an in-order pipeline: load-use bubbles,
// taken-branch flushes, data-memory wait stalls and perf counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int FLUSH_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [6:0]  ex_opcode,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken_ex,
  input  logic        mem_busy,
  output logic        stall_if,
  output logic        stall_dec,
  output logic        nop_dec,
  output logic        flush_if,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN,
    BUBBLE,
    FLUSH,
    MEMWAIT
  } state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LU_INIT = 3'(LOAD_USE_BUBBLES - 1);
  localparam state_t FL_NEXT = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
  localparam state_t LU_NEXT = (LOAD_USE_BUBBLES == 1) ? RUN : BUBBLE;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic rs1_used, rs2_used, load_use;

  always_comb begin
    rs1_used = !(id_opcode == OP_LUI || id_opcode == OP_AUIPC ||
                 id_opcode == OP_JAL);
    rs2_used = (id_opcode == OP_REG) || (id_opcode == OP_STORE) ||
               (id_opcode == OP_BR);
    load_use = (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
               ((rs1_used && ex_rd == id_rs1) ||
                (rs2_used && ex_rd == id_rs2));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_if  = 1'b0;
    stall_dec = 1'b0;
    nop_dec   = 1'b0;
    flush_if  = 1'b0;
    if (reset) begin
      state_d  = RUN;
      cnt_d    = 3'd0;
      nop_dec  = 1'b1;
      flush_if = 1'b1;
    end else if (branch_taken_ex) begin
      state_d  = FL_NEXT;
      cnt_d    = FL_INIT;
      nop_dec  = 1'b1;
      flush_if = 1'b1;
    end else if (mem_busy) begin
      stall_if  = 1'b1;
      stall_dec = 1'b1;
      // A pending flush is only paused, not dropped
      if (state_q != FLUSH) begin
        state_d = MEMWAIT;
      end
    end else begin
      unique case (state_q)
        BUBBLE: begin
          stall_if = 1'b1;
          nop_dec  = 1'b1;
          state_d  = (cnt_q <= 3'd1) ? RUN : BUBBLE;
          cnt_d    = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        end
        FLUSH: begin
          flush_if = 1'b1;
          nop_dec  = 1'b1;
          state_d  = (cnt_q <= 3'd1) ? RUN : FLUSH;
          cnt_d    = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        end
        default: begin
          state_d = RUN;
          if (load_use) begin
            stall_if = 1'b1;
            nop_dec  = 1'b1;
            state_d  = LU_NEXT;
            cnt_d    = LU_INIT;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = 32'd0;
      flush_cnt_d = 32'd0;
    end else begin
      if (stall_if) stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush_if) flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl: each vector
// queues its expected outputs, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1, id_rs2;
  logic [6:0]  ex_opcode;
  logic [4:0]  ex_rd;
  logic        branch_taken_ex, mem_busy;
  logic        stall_if, stall_dec, nop_dec, flush_if;
  logic [31:0] stall_count, flush_count;

  typedef struct {
    logic [3:0]  o;
    logic [31:0] sc;
    logic [31:0] fc;
    int          id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vid    = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .id_opcode       (id_opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_opcode       (ex_opcode),
    .ex_rd           (ex_rd),
    .branch_taken_ex (branch_taken_ex),
    .mem_busy        (mem_busy),
    .stall_if        (stall_if),
    .stall_dec       (stall_dec),
    .nop_dec         (nop_dec),
    .flush_if        (flush_if),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [3:0] o;
      e = q.pop_front();
      o = {stall_if, stall_dec, nop_dec, flush_if};
      checks++;
      if (o !== e.o) begin
        errors++;
        $display("FAIL v%0d outs(if,dec,nop,flush) got %b want %b",
                 e.id, o, e.o);
      end
      checks++;
      if (stall_count !== e.sc) begin
        errors++;
        $display("FAIL v%0d stall_count got %h want %h",
                 e.id, stall_count, e.sc);
      end
      checks++;
      if (flush_count !== e.fc) begin
        errors++;
        $display("FAIL v%0d flush_count got %h want %h",
                 e.id, flush_count, e.fc);
      end
      checks++;
      if (stall_dec && nop_dec) begin
        errors++;
        $display("FAIL v%0d stall_dec_and_nop_dec got 1 want 0", e.id);
      end
    end
  end

  task automatic go(input logic [3:0] eo,
                    input logic [31:0] sc,
                    input logic [31:0] fc);
    exp_t e;
    e.o  = eo;
    e.sc = sc;
    e.fc = fc;
    e.id = vid;
    vid++;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset           = 1'b0;
    id_opcode       = 7'b0010011;
    id_rs1          = 5'd1;
    id_rs2          = 5'd2;
    ex_opcode       = 7'b0110011;
    ex_rd           = 5'd3;
    branch_taken_ex = 1'b0;
    mem_busy        = 1'b0;
  endtask

  task automatic ldu();
    ex_opcode = 7'b0000011;
    ex_rd     = 5'd5;
    id_opcode = 7'b0110011;
    id_rs1    = 5'd1;
    id_rs2    = 5'd5;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    // reset: flush + nop, counters cleared
    go(4'b0011, 0, 0);
    go(4'b0011, 0, 0);
    idle();
    go(4'b0000, 0, 0);
    // load-use on rs2 of R-type
    ldu();
    go(4'b1010, 0, 0);
    idle();
    go(4'b0000, 1, 0);
    // x0 destination
    ex_opcode = 7'b0000011; ex_rd = 5'd0;
    id_opcode = 7'b0110011; id_rs1 = 5'd0; id_rs2 = 5'd0;
    go(4'b0000, 1, 0);
    // LUI does not read rs1
    ex_rd = 5'd7; id_opcode = 7'b0110111;
    id_rs1 = 5'd7; id_rs2 = 5'd7;
    go(4'b0000, 1, 0);
    // I-type does not read rs2
    id_opcode = 7'b0010011; id_rs1 = 5'd1;
    go(4'b0000, 1, 0);
    // store reads rs2
    id_opcode = 7'b0100011;
    go(4'b1010, 1, 0);
    idle();
    go(4'b0000, 2, 0);
    // branch: two flush cycles
    branch_taken_ex = 1'b1;
    go(4'b0011, 2, 0);
    branch_taken_ex = 1'b0;
    go(4'b0011, 2, 1);
    go(4'b0000, 2, 2);
    // branch + mem_busy + load_use together
    ldu(); branch_taken_ex = 1'b1; mem_busy = 1'b1;
    go(4'b0011, 2, 2);
    branch_taken_ex = 1'b0; mem_busy = 1'b0;
    go(4'b0011, 2, 3);
    idle(); mem_busy = 1'b1;
    go(4'b1100, 2, 4);
    go(4'b1100, 3, 4);
    go(4'b1100, 4, 4);
    mem_busy = 1'b0;
    go(4'b0000, 5, 4);
    // mem_busy during flush pauses the countdown
    branch_taken_ex = 1'b1;
    go(4'b0011, 5, 4);
    branch_taken_ex = 1'b0; mem_busy = 1'b1;
    go(4'b1100, 5, 5);
    mem_busy = 1'b0;
    go(4'b0011, 6, 5);
    go(4'b0000, 6, 6);
    // MEMWAIT exit evaluates load-use normally
    ldu(); mem_busy = 1'b1;
    go(4'b1100, 6, 6);
    mem_busy = 1'b0;
    go(4'b1010, 7, 6);
    idle();
    go(4'b0000, 8, 6);
    // reset inside FLUSH with cnt=1
    branch_taken_ex = 1'b1;
    go(4'b0011, 8, 6);
    branch_taken_ex = 1'b0; reset = 1'b1;
    go(4'b0011, 8, 7);
    reset = 1'b0;
    go(4'b0000, 0, 0);
    go(4'b0000, 0, 0);
    // stall counter wrap
    mem_busy = 1'b1;
    go(4'b1100, 0, 0);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    go(4'b1100, 32'hFFFF_FFFF, 0);
    mem_busy = 1'b0;
    go(4'b0000, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_USE_BUBBLES, default 1: bubbles inserted per load-use hazard (1..7).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2: cycles nop_dec/flush_if held after a taken branch (1..7).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port id_opcode, input, 7: opcode of the instruction in IF/ID.
REQ-006 SHALL have ports id_rs1 and id_rs2, input, 5 each: source registers of the IF/ID instruction.
REQ-007 SHALL have ports ex_opcode and ex_rd, input, 7 and 5: opcode and rd at the ID/EX register outputs.
REQ-008 SHALL have port branch_taken_ex, input, 1: EX resolved a taken branch/jump this cycle.
REQ-009 SHALL have port mem_busy, input, 1: data memory not ready; whole pipeline must hold.
REQ-010 SHALL have port stall_if, output, 1: hold PC and IF/ID.
REQ-011 SHALL have port stall_dec, output, 1: drives the ID/EX register stall input.
REQ-012 SHALL have port nop_dec, output, 1: drives the ID/EX register nop_output input (bubble insert).
REQ-013 SHALL have port flush_if, output, 1: replace IF/ID contents with NOP.
REQ-014 SHALL have ports stall_count and flush_count, output, 32 each: performance counters.

Function
REQ-015 SHALL implement FSM states RUN, BUBBLE, FLUSH, MEMWAIT plus a 3-bit down-counter cnt; outputs are Mealy (combinational from state, cnt, inputs).
REQ-016 SHALL define rs1 used unless id_opcode is 0110111, 0010111 or 1101111; rs2 used only for id_opcode 0110011, 0100011, 1100011.
REQ-017 SHALL flag load_use when ex_opcode==0000011, ex_rd!=0, and ex_rd equals a used id_rs1 or id_rs2; register x0 never creates a hazard.
REQ-018 SHALL evaluate events in priority order branch_taken_ex > mem_busy > load_use in every state.
REQ-019 SHALL, on branch_taken_ex in any state, assert flush_if=1, nop_dec=1, stall_if=0, stall_dec=0 that cycle, load cnt=FLUSH_CYCLES-1, and go to FLUSH (stay RUN if FLUSH_CYCLES==1).
REQ-020 SHALL, in FLUSH without a new branch, assert flush_if=1 and nop_dec=1, decrement cnt, return to RUN in the cycle cnt==0; mem_busy there suspends countdown and asserts stall_if/stall_dec only.
REQ-021 SHALL, on mem_busy without branch, assert stall_if=1, stall_dec=1, nop_dec=0, flush_if=0, enter/stay in MEMWAIT; first cycle with mem_busy=0 returns to RUN with normal evaluation.
REQ-022 SHALL, on load_use in RUN, assert stall_if=1, nop_dec=1, stall_dec=0 that cycle, load cnt=LOAD_USE_BUBBLES-1, go to BUBBLE (stay RUN if LOAD_USE_BUBBLES==1).
REQ-023 SHALL, in BUBBLE, hold stall_if=1, nop_dec=1, decrement cnt, return to RUN at cnt==0; load_use not re-detected while in BUBBLE.
REQ-024 SHALL drive all outputs 0 in RUN with no event.
REQ-025 SHALL increment stall_count each cycle stall_if=1 and flush_count each cycle flush_if=1; both wrap 0xFFFFFFFF->0.
REQ-026 SHALL never assert stall_dec and nop_dec together.

Reset
REQ-027 SHALL, while reset=1, force state RUN, cnt=0, stall_count=0, flush_count=0.
REQ-028 SHALL, while reset=1, drive flush_if=1, nop_dec=1, stall_if=0, stall_dec=0, flushing the pipeline; reset mid-FLUSH/BUBBLE/MEMWAIT aborts the sequence, next cycle after deassertion is RUN.
REQ-029 SHALL not increment counters during reset cycles.

Verification
REQ-030 SHALL test load-use: ex_opcode=0000011, ex_rd=5, id_opcode=0110011, id_rs2=5 -> stall_if=1, nop_dec=1 for exactly 1 cycle (default), stall_count=1.
REQ-031 SHALL test x0/unused: ex_rd=0, or id_opcode=0110111 with id_rs1=ex_rd -> no stall, all outputs 0.
REQ-032 SHALL test branch: branch_taken_ex pulse 1 cycle -> flush_if=nop_dec=1 for 2 cycles, flush_count=2.
REQ-033 SHALL test simultaneous branch_taken_ex, mem_busy, load_use -> branch response only; mem_busy held 3 cycles in MEMWAIT -> stall_if=stall_dec=1 for 3 cycles, stall_count=3.
REQ-034 SHALL test reset asserted in FLUSH with cnt=1 -> next cycle flush_if=nop_dec=1, counters 0; after release all outputs 0.
REQ-035 SHALL test counter wrap: preload path to stall_count=0xFFFFFFFF via long mem_busy -> next stall cycle gives 0.
